// File: rtl/stash_ctrl_if.sv
// Signal bundle between the stopwatch front end / lap Stash and the stash sequencer.
interface stash_ctrl_if #(
    parameter int DEPTH = 5
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = $clog2(DEPTH + 1);

    logic             lap_btn;
    logic             next_btn;
    logic             auto_en;
    logic [7:0]       time_in;
    logic [7:0]       sample_in;
    logic             sample_in_valid;
    logic             next_sample;
    logic [PTR_W-1:0] read_idx;
    logic [CNT_W-1:0] count;
    logic             empty;
    logic             full;
    logic             busy;
    logic             lap_drop;

    modport master (
        output lap_btn, next_btn, auto_en, time_in,
        input  sample_in, sample_in_valid, next_sample, read_idx,
               count, empty, full, busy, lap_drop
    );

    modport slave (
        input  lap_btn, next_btn, auto_en, time_in,
        output sample_in, sample_in_valid, next_sample, read_idx,
               count, empty, full, busy, lap_drop
    );
endinterface

// File: rtl/stash_ctrl.sv
// Lap Stash sequencer: captures laps, issues read-advance steps and wraps browsing past empty slots.
// state   | meaning
// S_EMPTY | no laps stored, steps ignored
// S_READY | laps stored, steps advance read_idx by one
// S_SKIP  | wrap burst pushing the Stash pointer through empty slots back to 0
module stash_ctrl #(
    parameter int DEPTH    = 5,
    parameter int TICK_DIV = 100000000
) (
    input  logic        clk,
    input  logic        reset,
    stash_ctrl_if.slave bus
);
    localparam int PTR_W  = $clog2(DEPTH);
    localparam int CNT_W  = $clog2(DEPTH + 1);
    localparam int TICK_W = $clog2(TICK_DIV);

    typedef enum logic [1:0] {S_EMPTY, S_READY, S_SKIP} state_t;

    state_t            state;
    logic [7:0]        lap_reg;
    logic [CNT_W-1:0]  count;
    logic [CNT_W-1:0]  burst_cnt;
    logic [PTR_W-1:0]  read_idx;
    logic [PTR_W-1:0]  idx_eff;
    logic [TICK_W-1:0] tick_cnt;
    logic              sample_in_valid;
    logic              next_sample;
    logic              busy;
    logic              lap_drop;
    logic              next_pend;
    logic              tick;
    logic              lap_ok;
    logic              step_take;
    logic              have_step;
    logic              issue;
    logic              single;

    // idx_eff is the read index once the strobe currently on the wire has been consumed by the Stash
    always_comb begin
        tick      = bus.auto_en && (count != '0) && (tick_cnt == TICK_W'(TICK_DIV - 1));
        lap_ok    = bus.lap_btn && (count != CNT_W'(DEPTH));
        step_take = (bus.next_btn || tick) && (count != '0) && (state != S_SKIP) && !next_pend;
        have_step = next_pend || step_take;
        issue     = have_step && !lap_ok;
        idx_eff   = read_idx;
        if (next_sample) begin
            if (state == S_READY) begin
                idx_eff = (read_idx == PTR_W'(DEPTH - 1)) ? '0 : read_idx + PTR_W'(1);
            end else if (state == S_SKIP && burst_cnt == '0) begin
                idx_eff = '0;
            end
        end
        single = (count == CNT_W'(DEPTH)) || ((CNT_W'(idx_eff) + CNT_W'(1)) < count);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state           <= S_EMPTY;
            lap_reg         <= '0;
            count           <= '0;
            burst_cnt       <= '0;
            read_idx        <= '0;
            tick_cnt        <= '0;
            sample_in_valid <= 1'b0;
            next_sample     <= 1'b0;
            busy            <= 1'b0;
            lap_drop        <= 1'b0;
            next_pend       <= 1'b0;
        end else begin
            sample_in_valid <= lap_ok;
            lap_drop        <= bus.lap_btn && (count == CNT_W'(DEPTH));
            next_sample     <= 1'b0;
            read_idx        <= idx_eff;
            if (lap_ok) begin
                lap_reg <= bus.time_in;
                count   <= count + CNT_W'(1);
            end
            if (!bus.auto_en || count == '0 || tick) begin
                tick_cnt <= '0;
            end else begin
                tick_cnt <= tick_cnt + TICK_W'(1);
            end
            case (state)
                S_EMPTY: begin
                    if (lap_ok) state <= S_READY;
                end
                S_READY: begin
                    if (issue) begin
                        next_pend   <= 1'b0;
                        next_sample <= 1'b1;
                        if (!single) begin
                            // first burst pulse goes out now, counter holds the remainder
                            state     <= S_SKIP;
                            busy      <= 1'b1;
                            burst_cnt <= CNT_W'(DEPTH) - count;
                        end
                    end else if (have_step) begin
                        next_pend <= 1'b1;
                    end
                end
                S_SKIP: begin
                    if (burst_cnt == '0) begin
                        state <= S_READY;
                        busy  <= 1'b0;
                    end else if (!lap_ok) begin
                        next_sample <= 1'b1;
                        burst_cnt   <= burst_cnt - CNT_W'(1);
                    end
                end
                default: state <= S_EMPTY;
            endcase
        end
    end

    assign bus.sample_in       = lap_reg;
    assign bus.sample_in_valid = sample_in_valid;
    assign bus.next_sample     = next_sample;
    assign bus.read_idx        = read_idx;
    assign bus.count           = count;
    assign bus.empty           = (count == '0);
    assign bus.full            = (count == CNT_W'(DEPTH));
    assign bus.busy            = busy;
    assign bus.lap_drop        = lap_drop;
endmodule

// File: tb/tb_stash_ctrl.sv
// Scoreboard bench for stash_ctrl: a Stash-pointer reference model predicts strobes and status.
module tb_stash_ctrl;
    localparam int DEPTH    = 5;
    localparam int TICK_DIV = 4;

    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    stash_ctrl_if #(.DEPTH(DEPTH)) bus ();

    stash_ctrl #(.DEPTH(DEPTH), .TICK_DIV(TICK_DIV)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    typedef struct packed {
        int         cyc;
        logic [1:0] kind;   // 0 write, 1 step, 2 drop
        logic [7:0] data;
    } ev_t;

    typedef struct {
        int         cnt;
        int         idx;
        bit         busy;
        bit         empty;
        bit         full;
        logic [7:0] data;
    } st_t;

    ev_t ev_q[$];
    st_t st_q[$];
    int  total = 0;
    int  bad = 0;
    int  cyc = 0;

    task automatic chk(input string nm, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d at cycle %0d", nm, act, exp, cyc);
        end
    endtask

    // Reference model: tracks the Stash's own read pointer; a burst ends when that pointer lands on 0.
    int         m_cnt, m_ptr, m_vis, m_tick;
    bit         m_pend, m_skip, m_ns;
    logic [7:0] m_data;

    always @(posedge clk) begin : model
        bit was_skip, tk, wr, dr, acc, ns_nx;
        st_t s;
        cyc++;
        if (reset) begin
            m_cnt = 0; m_ptr = 0; m_vis = 0; m_tick = 0;
            m_pend = 0; m_skip = 0; m_ns = 0; m_data = 8'h00;
            ev_q.delete();
        end else begin
            was_skip = m_skip;
            if (m_ns) begin
                m_ptr = (m_ptr + 1) % DEPTH;
                if (m_skip) begin
                    if (m_ptr == 0) begin
                        m_skip = 0;
                        m_vis  = 0;
                    end
                end else begin
                    m_vis = m_ptr;
                end
            end
            tk = bus.auto_en && m_cnt > 0 && m_tick == TICK_DIV - 1;
            if (!bus.auto_en || m_cnt == 0) m_tick = 0;
            else m_tick = (m_tick + 1) % TICK_DIV;
            wr  = bus.lap_btn && m_cnt < DEPTH;
            dr  = bus.lap_btn && m_cnt == DEPTH;
            acc = (bus.next_btn || tk) && m_cnt > 0 && !was_skip && !m_pend;
            ns_nx = 0;
            if (wr) begin
                m_cnt++;
                m_data = bus.time_in;
                if (acc) m_pend = 1;
            end else if (m_skip) begin
                ns_nx = 1;
            end else if (m_pend || acc) begin
                m_pend = 0;
                ns_nx  = 1;
                if (m_vis == m_cnt - 1 && m_cnt < DEPTH) m_skip = 1;
            end
            m_ns = ns_nx;
            if (wr)    ev_q.push_back('{cyc, 2'd0, m_data});
            if (ns_nx) ev_q.push_back('{cyc, 2'd1, 8'h00});
            if (dr)    ev_q.push_back('{cyc, 2'd2, 8'h00});
        end
        s.cnt = m_cnt; s.idx = m_vis; s.busy = m_skip;
        s.empty = (m_cnt == 0); s.full = (m_cnt == DEPTH); s.data = m_data;
        st_q.push_back(s);
    end

    always @(negedge clk) begin : monitor
        st_t s;
        ev_t e;
        bit  pres;
        if (st_q.size() > 0) begin
            s = st_q.pop_front();
            chk("count",     int'(bus.count),    s.cnt);
            chk("read_idx",  int'(bus.read_idx), s.idx);
            chk("busy",      int'(bus.busy),     int'(s.busy));
            chk("empty",     int'(bus.empty),    int'(s.empty));
            chk("full",      int'(bus.full),     int'(s.full));
            chk("sample_in", int'(bus.sample_in), int'(s.data));
            chk("strobe_excl", int'(bus.sample_in_valid && bus.next_sample), 0);
            while (ev_q.size() > 0 && ev_q[0].cyc < cyc) begin
                total++;
                bad++;
                $display("FAIL ev_missing: kind %0d expected at cycle %0d, not seen by cycle %0d",
                         ev_q[0].kind, ev_q[0].cyc, cyc);
                void'(ev_q.pop_front());
            end
            for (int k = 0; k < 3; k++) begin
                pres = (k == 0) ? bus.sample_in_valid : (k == 1) ? bus.next_sample : bus.lap_drop;
                if (pres) begin
                    if (ev_q.size() == 0) begin
                        total++;
                        bad++;
                        $display("FAIL ev_unexpected: kind %0d seen at cycle %0d, none expected", k, cyc);
                    end else begin
                        e = ev_q.pop_front();
                        chk("ev_cycle", cyc, e.cyc);
                        chk("ev_kind", k, int'(e.kind));
                        if (k == 0) chk("wr_data", int'(bus.sample_in), int'(e.data));
                    end
                end
            end
        end
    end

    task automatic drive(input bit l, input bit n, input logic [7:0] t);
        @(negedge clk);
        bus.lap_btn  = l;
        bus.next_btn = n;
        bus.time_in  = t;
    endtask

    task automatic idle(input int k);
        repeat (k) drive(1'b0, 1'b0, 8'($urandom));
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset        = 1'b1;
        bus.lap_btn  = 1'b0;
        bus.next_btn = 1'b0;
        bus.auto_en  = 1'b0;
        @(negedge clk);
        reset = 1'b0;
    endtask

    initial begin
        bus.lap_btn  = 1'b0;
        bus.next_btn = 1'b0;
        bus.auto_en  = 1'b0;
        bus.time_in  = 8'h00;
        do_reset();

        // first lap
        drive(1'b1, 1'b0, 8'h12);
        idle(3);

        // three laps, two single steps, then the wrap burst
        do_reset();
        drive(1'b1, 1'b0, 8'h01);
        drive(1'b1, 1'b0, 8'h02);
        drive(1'b1, 1'b0, 8'h03);
        idle(2);
        drive(1'b0, 1'b1, 8'h00); idle(3);
        drive(1'b0, 1'b1, 8'h00); idle(3);
        drive(1'b0, 1'b1, 8'h00); idle(8);

        // full Stash: dropped lap, wrap at read_idx=4 is a single pulse
        do_reset();
        for (int i = 0; i < 5; i++) drive(1'b1, 1'b0, 8'(8'h40 + i));
        drive(1'b1, 1'b0, 8'hEE);
        idle(2);
        for (int i = 0; i < 5; i++) begin
            drive(1'b0, 1'b1, 8'h00);
            idle(2);
        end

        // lap and step in the same cycle
        do_reset();
        drive(1'b1, 1'b0, 8'hA1);
        drive(1'b1, 1'b0, 8'hA2);
        idle(1);
        drive(1'b1, 1'b1, 8'hA3);
        idle(4);

        // auto-scroll with two laps
        do_reset();
        drive(1'b1, 1'b0, 8'h21);
        drive(1'b1, 1'b0, 8'h22);
        bus.auto_en = 1'b1;
        idle(20);
        bus.auto_en = 1'b0;
        idle(3);

        // reset in the middle of a burst
        do_reset();
        drive(1'b1, 1'b0, 8'h31);
        drive(1'b1, 1'b0, 8'h32);
        idle(1);
        drive(1'b0, 1'b1, 8'h00);
        idle(1);
        drive(1'b0, 1'b1, 8'h00);
        idle(1);
        do_reset();
        idle(2);

        // randomized traffic
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 399) == 0) do_reset();
            if ($urandom_range(0, 29) == 0) bus.auto_en = ~bus.auto_en;
            drive($urandom_range(0, 5) == 0, $urandom_range(0, 4) == 0, 8'($urandom));
        end

        bus.auto_en = 1'b0;
        idle(12);
        chk("ev_drain", ev_q.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
